// File: rtl/gpu_graphics_scanout_pkg.sv
// Shared constants for the graphics framebuffer scanout: mode encodings,
// page geometry and per-mode row/frame sizes.
package gpu_graphics_scanout_pkg;

   localparam logic [1:0]  GFX_MODE_1BPP   = 2'd0;
   localparam logic [1:0]  GFX_MODE_2BPP   = 2'd1;
   localparam logic [1:0]  GFX_MODE_4BPP   = 2'd2;

   localparam logic [14:0] GFX_PAGE_STRIDE = 15'h2000;
   localparam int          GFX_PAGE_BYTES  = 8000;

   localparam int GFX_ROW_PIX_1BPP   = 320;
   localparam int GFX_ROW_PIX_2BPP   = 160;
   localparam int GFX_ROW_PIX_4BPP   = 160;
   localparam int GFX_FRAME_PIX_1BPP = 64000;
   localparam int GFX_FRAME_PIX_2BPP = 32000;
   localparam int GFX_FRAME_PIX_4BPP = 16000;

   // Mode 3 is an alias of 1bpp.
   function automatic logic [1:0] gfx_mode_norm(input logic [1:0] m);
      return (m == 2'd3) ? GFX_MODE_1BPP : m;
   endfunction

   function automatic logic [3:0] gfx_ppb(input logic [1:0] m);
      case (m)
         GFX_MODE_2BPP: return 4'd4;
         GFX_MODE_4BPP: return 4'd2;
         default:       return 4'd8;
      endcase
   endfunction

   function automatic logic [8:0] gfx_col_last(input logic [1:0] m);
      case (m)
         GFX_MODE_2BPP: return 9'(GFX_ROW_PIX_2BPP - 1);
         GFX_MODE_4BPP: return 9'(GFX_ROW_PIX_4BPP - 1);
         default:       return 9'(GFX_ROW_PIX_1BPP - 1);
      endcase
   endfunction

   function automatic logic [7:0] gfx_row_last(input logic [1:0] m);
      case (m)
         GFX_MODE_2BPP: return 8'(GFX_FRAME_PIX_2BPP / GFX_ROW_PIX_2BPP - 1);
         GFX_MODE_4BPP: return 8'(GFX_FRAME_PIX_4BPP / GFX_ROW_PIX_4BPP - 1);
         default:       return 8'(GFX_FRAME_PIX_1BPP / GFX_ROW_PIX_1BPP - 1);
      endcase
   endfunction

endpackage

// File: rtl/gpu_graphics_pixel_unpack.sv
// Byte-to-pixel unpacker: 2-entry byte buffer feeding an MSB-first shift
// register whose top bits are the registered pixel output.
module gpu_graphics_pixel_unpack
   import gpu_graphics_scanout_pkg::*;
(
   input  logic       clk_pixel,
   input  logic       rst,
   input  logic       i_flush,
   input  logic [1:0] i_mode,
   input  logic       i_byte_vld,
   input  logic [7:0] i_byte,
   input  logic       i_ready,
   output logic       o_valid,
   output logic [3:0] o_data,
   output logic [1:0] o_buf_cnt
);

   logic [1:0][7:0] r_buf;
   logic [1:0]      r_cnt;
   logic [7:0]      r_sh;
   logic [3:0]      r_left;

   logic       w_xfer, w_need, w_pop, w_byp, w_push;
   logic [7:0] w_sh_next;
   logic [3:0] w_pix;

   assign w_xfer = (r_left != 4'd0) && i_ready;
   // Reload the shifter when it is empty or its last pixel leaves this cycle.
   assign w_need = (r_left == 4'd0) || ((r_left == 4'd1) && w_xfer);
   assign w_pop  = w_need && (r_cnt != 2'd0);
   assign w_byp  = w_need && (r_cnt == 2'd0) && i_byte_vld;
   assign w_push = i_byte_vld && !w_byp;

   always_comb begin
      w_sh_next = r_sh << 4;
      w_pix     = r_sh[7:4];
      case (i_mode)
         GFX_MODE_1BPP: begin
            w_sh_next = r_sh << 1;
            w_pix     = {3'b000, r_sh[7]};
         end
         GFX_MODE_2BPP: begin
            w_sh_next = r_sh << 2;
            w_pix     = {2'b00, r_sh[7:6]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         r_buf  <= '0;
         r_cnt  <= 2'd0;
         r_sh   <= 8'd0;
         r_left <= 4'd0;
      end else if (i_flush) begin
         r_cnt  <= 2'd0;
         r_left <= 4'd0;
      end else begin
         if (w_pop) begin
            r_sh   <= r_buf[0];
            r_left <= gfx_ppb(i_mode);
         end else if (w_byp) begin
            r_sh   <= i_byte;
            r_left <= gfx_ppb(i_mode);
         end else if (w_xfer) begin
            r_sh   <= w_sh_next;
            r_left <= r_left - 4'd1;
         end
         case ({w_push, w_pop})
            2'b10: begin
               r_buf[r_cnt[0]] <= i_byte;
               r_cnt           <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_buf[0] <= r_buf[1];
               r_cnt    <= r_cnt - 2'd1;
            end
            2'b11: begin
               if (r_cnt == 2'd1) begin
                  r_buf[0] <= i_byte;
               end else begin
                  r_buf[0] <= r_buf[1];
                  r_buf[1] <= i_byte;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_valid   = (r_left != 4'd0);
   assign o_data    = o_valid ? w_pix : 4'd0;
   assign o_buf_cnt = r_cnt;

endmodule

// File: rtl/gpu_graphics_scanout.sv
// Graphics framebuffer scanout: fetches one page of VRAM per frame and streams
// unpacked palette indices with row/frame markers over valid/ready.
module gpu_graphics_scanout
   import gpu_graphics_scanout_pkg::*;
#(
   parameter int                ADDR_W      = 15,
   parameter logic [ADDR_W-1:0] PAGE_STRIDE = GFX_PAGE_STRIDE,
   parameter int                PAGE_BYTES  = GFX_PAGE_BYTES
) (
   input  logic              clk_pixel,
   input  logic              rst,
   input  logic              enable,
   input  logic              frame_start,
   input  logic [1:0]        mode,
   input  logic [1:0]        page_sel,
   output logic [ADDR_W-1:0] vram_addr,
   input  logic [7:0]        vram_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [3:0]        pix_data,
   output logic              line_end,
   output logic              frame_end,
   output logic              busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_offset;
   logic              r_inflight;
   logic [1:0]        r_mode;
   logic [8:0]        r_col;
   logic [7:0]        r_row;

   logic              w_start, w_issue, w_last_off, w_xfer;
   logic [1:0]        w_buf_cnt;
   logic [ADDR_W-1:0] w_base;

   assign w_start    = frame_start && enable;
   assign w_base     = {{(ADDR_W-2){1'b0}}, page_sel} * PAGE_STRIDE;
   // The in-flight byte has a reserved buffer slot, so the buffer never overflows.
   assign w_issue    = (r_state == S_FETCH) &&
                       (({1'b0, w_buf_cnt} + {2'b00, r_inflight}) < 3'd2);
   assign w_last_off = (r_offset == ADDR_W'(PAGE_BYTES - 1));
   assign w_xfer     = pix_valid && pix_ready;

   assign line_end   = pix_valid && (r_col == gfx_col_last(r_mode));
   assign frame_end  = line_end && (r_row == gfx_row_last(r_mode));

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         vram_addr  <= '0;
         r_offset   <= '0;
         r_inflight <= 1'b0;
         busy       <= 1'b0;
         r_mode     <= GFX_MODE_1BPP;
         r_col      <= 9'd0;
         r_row      <= 8'd0;
      end else if (w_start) begin
         r_state    <= S_FETCH;
         vram_addr  <= w_base;
         r_offset   <= '0;
         r_inflight <= 1'b0;
         busy       <= 1'b1;
         r_mode     <= gfx_mode_norm(mode);
         r_col      <= 9'd0;
         r_row      <= 8'd0;
      end else begin
         r_inflight <= w_issue;
         case (r_state)
            S_FETCH: begin
               if (w_issue) begin
                  if (w_last_off) begin
                     r_state <= S_DRAIN;
                  end else begin
                     vram_addr <= vram_addr + ADDR_W'(1);
                     r_offset  <= r_offset + ADDR_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (w_xfer && frame_end) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: ;
         endcase
         if (w_xfer) begin
            if (line_end) begin
               r_col <= 9'd0;
               r_row <= frame_end ? 8'd0 : r_row + 8'd1;
            end else begin
               r_col <= r_col + 9'd1;
            end
         end
      end
   end

   gpu_graphics_pixel_unpack u_unpack (
      .clk_pixel  (clk_pixel),
      .rst        (rst),
      .i_flush    (w_start),
      .i_mode     (r_mode),
      .i_byte_vld (r_inflight),
      .i_byte     (vram_data),
      .i_ready    (pix_ready),
      .o_valid    (pix_valid),
      .o_data     (pix_data),
      .o_buf_cnt  (w_buf_cnt)
   );

endmodule
